// File: rtl/swizzle_pkg.sv
// Shared constants and state types for the DRAM-to-CRAM swizzle unit.
package swizzle_pkg;

  localparam int unsigned SWZ_N      = 40;
  localparam int unsigned SWZ_ADDR_W = 16;
  localparam int unsigned SWZ_STRIDE = 4;

  typedef enum logic {
    D_IDLE,
    D_DRAIN
  } drain_state_t;

  typedef enum logic [1:0] {
    T_IDLE,
    T_LOAD,
    T_FLUSH
  } xfer_state_t;

endpackage

// File: rtl/swizzle_tile_buffer.sv
// N x N bit tile store: whole-tile synchronous clear, row write, column read.
module swizzle_tile_buffer #(
  parameter int unsigned N     = 40,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_row,
  input  logic [N-1:0]     wr_data,
  input  logic [IDX_W-1:0] rd_col,
  output logic [N-1:0]     rd_data
);

  logic [N-1:0] rows [N];

  always_ff @(posedge clk) begin
    if (clear) begin
      rows <= '{default: '0};
    end else if (wr_en) begin
      rows[wr_row] <= wr_data;
    end
  end

  // Output bit k is row k sampled at the selected column.
  always_comb begin
    rd_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      rd_data[k] = rows[k][rd_col];
    end
  end

endmodule

// File: rtl/swizzle_d2c_tile.sv
// Ping-pong tile transpose from the DRAM read stream to the CRAM write port.
// Optional SWIZZLE_D2C_BIT_REVERSE_EN selects the legacy reversed CRAM bit order.
module swizzle_d2c_tile
  import swizzle_pkg::*;
#(
  parameter int unsigned N      = SWZ_N,
  parameter int unsigned ADDR_W = SWZ_ADDR_W,
  parameter int unsigned STRIDE = SWZ_STRIDE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_data,
  input  logic              in_last,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              dma_mode,
  output logic [N-1:0]      ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic              idle,
  output logic              done
);

  localparam int unsigned       IDX_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);

  xfer_state_t       xfer_state;
  drain_state_t      drain_state;
  logic              load_sel;
  logic              load_full;
  logic              load_last;
  logic              drain_last;
  logic [IDX_W-1:0]  row_cnt;
  logic [IDX_W-1:0]  col_cnt;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] tile_idx;
  logic [ADDR_W-1:0] drain_addr;

  logic              accept;
  logic              complete;
  logic              drain_fin;
  logic              can_swap;
  logic              swap;
  logic              done_pre;
  logic              xfer_end;
  logic [ADDR_W-1:0] tile_base;

  logic [N-1:0]      ping_col;
  logic [N-1:0]      pong_col;
  logic [N-1:0]      col_word;
  logic [N-1:0]      swz_word;

  logic              we_c;
  logic [N-1:0]      data_c;
  logic [ADDR_W-1:0] addr_c;
  logic              we_q;
  logic [N-1:0]      data_q;
  logic [ADDR_W-1:0] addr_q;
  logic              done_d1;
  logic              done_d2;

  assign in_ready  = !load_full && (xfer_state != T_FLUSH);
  assign accept    = in_valid && in_ready;
  assign complete  = accept && (in_last || (row_cnt == LAST_IDX));
  assign drain_fin = (drain_state == D_DRAIN) && (col_cnt == LAST_IDX);
  assign can_swap  = (drain_state == D_IDLE) || drain_fin;
  assign swap      = (complete && can_swap) || (load_full && drain_fin);
  assign done_pre  = drain_fin && drain_last;
  // Transfer closes together with the done pulse, so idle/in_ready follow the output stage.
  assign xfer_end  = dma_mode ? done_pre : done_d1;
  // A single-beat first tile swaps on the same edge that samples base_addr.
  assign tile_base = (xfer_state == T_IDLE) ? base_addr : base_q;
  assign idle      = (xfer_state == T_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      xfer_state  <= T_IDLE;
      drain_state <= D_IDLE;
      load_sel    <= 1'b0;
      load_full   <= 1'b0;
      load_last   <= 1'b0;
      drain_last  <= 1'b0;
      row_cnt     <= '0;
      col_cnt     <= '0;
      base_q      <= '0;
      tile_idx    <= '0;
      drain_addr  <= '0;
    end else begin
      if (accept && (xfer_state == T_IDLE)) begin
        base_q <= base_addr;
      end
      if (accept) begin
        row_cnt <= complete ? '0 : row_cnt + 1'b1;
      end

      case (xfer_state)
        T_IDLE:  if (accept) xfer_state <= in_last ? T_FLUSH : T_LOAD;
        T_LOAD:  if (accept && in_last) xfer_state <= T_FLUSH;
        T_FLUSH: if (xfer_end) xfer_state <= T_IDLE;
        default: xfer_state <= T_IDLE;
      endcase

      if (complete && !can_swap) begin
        load_full <= 1'b1;
        load_last <= in_last;
      end

      if (swap) begin
        load_sel    <= !load_sel;
        load_full   <= 1'b0;
        drain_state <= D_DRAIN;
        col_cnt     <= '0;
        drain_last  <= load_full ? load_last : in_last;
        drain_addr  <= tile_base + tile_idx;
        tile_idx    <= tile_idx + 1'b1;
      end else if (drain_state == D_DRAIN) begin
        col_cnt    <= col_cnt + 1'b1;
        drain_addr <= drain_addr + STRIDE_A;
        if (drain_fin) begin
          drain_state <= D_IDLE;
        end
      end

      if (xfer_end) begin
        tile_idx <= '0;
      end
    end
  end

  // The buffer leaving the drain side is cleared as it becomes the load side.
  swizzle_tile_buffer #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_ping (
    .clk     (clk),
    .clear   (reset || (swap && load_sel)),
    .wr_en   (accept && !load_sel),
    .wr_row  (row_cnt),
    .wr_data (in_data),
    .rd_col  (col_cnt),
    .rd_data (ping_col)
  );

  swizzle_tile_buffer #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pong (
    .clk     (clk),
    .clear   (reset || (swap && !load_sel)),
    .wr_en   (accept && load_sel),
    .wr_row  (row_cnt),
    .wr_data (in_data),
    .rd_col  (col_cnt),
    .rd_data (pong_col)
  );

  assign col_word = load_sel ? ping_col : pong_col;

`ifdef SWIZZLE_D2C_BIT_REVERSE_EN
  always_comb begin
    swz_word = '0;
    for (int unsigned i = 0; i < N; i++) begin
      swz_word[i] = col_word[N-1-i];
    end
  end
`else
  assign swz_word = col_word;
`endif

  assign we_c   = (drain_state == D_DRAIN);
  assign data_c = we_c ? swz_word : '0;
  assign addr_c = we_c ? drain_addr : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      done_d1 <= 1'b0;
      done_d2 <= 1'b0;
    end else begin
      we_q    <= we_c;
      data_q  <= data_c;
      addr_q  <= addr_c;
      done_d1 <= done_pre;
      done_d2 <= done_d1;
    end
  end

  assign ram_we   = dma_mode ? we_c   : we_q;
  assign ram_data = dma_mode ? data_c : data_q;
  assign ram_addr = dma_mode ? addr_c : addr_q;
  assign done     = dma_mode ? done_d1 : done_d2;

endmodule

// File: tb/tb_swizzle_d2c_tile.sv
// Directed bench for swizzle_d2c_tile at N=8, ADDR_W=16, STRIDE=4.
module tb_swizzle_d2c_tile;

  localparam int N      = 8;
  localparam int AW     = 16;
  localparam int STRIDE = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          in_last;
  logic [AW-1:0] base_addr;
  logic          dma_mode;
  logic [N-1:0]  ram_data;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic          idle;
  logic          done;

  always #5 clk = ~clk;

  swizzle_d2c_tile #(
    .N      (N),
    .ADDR_W (AW),
    .STRIDE (STRIDE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .base_addr (base_addr),
    .dma_mode  (dma_mode),
    .ram_data  (ram_data),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .idle      (idle),
    .done      (done)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Event log sampled on the falling edge.
  int            acc_n = 0, wr_n = 0, done_n = 0, rule_viol = 0;
  int            acc_cyc  [256];
  int            wr_cyc   [256];
  logic [N-1:0]  wr_data  [256];
  logic [AW-1:0] wr_addr  [256];
  int            done_cyc [64];
  bit            last_seen = 0, first_pend = 0;

  always @(negedge clk) begin
    if (last_seen && !idle && in_ready) rule_viol++;
    if (first_pend && idle) rule_viol++;
    first_pend = 0;
    if (idle) last_seen = 0;
    if (in_valid && in_ready && !reset) begin
      if (acc_n < 256) acc_cyc[acc_n] = cyc;
      acc_n++;
      if (in_last) last_seen = 1;
      if (idle) first_pend = 1;
    end
    if (ram_we) begin
      if (wr_n < 256) begin
        wr_cyc[wr_n]  = cyc;
        wr_data[wr_n] = ram_data;
        wr_addr[wr_n] = ram_addr;
      end
      wr_n++;
    end
    if (done) begin
      if (done_n < 64) done_cyc[done_n] = cyc;
      done_n++;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit            dma;
    logic [AW-1:0] base;
    int            nbeats;
    int            pat;
    int            gap_at;
    int            exp_writes;
    int            exp_lat;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [N-1:0] pat_byte(input int p, input int i);
    case (p)
      0:       return 8'h01 << (i % 8);
      1:       return 8'hFF;
      2:       return 8'(i * 29 + 3);
      default: return 8'hA5;
    endcase
  endfunction

  function automatic logic [N-1:0] model_data(input int nbeats, input int p, input int idx);
    logic [N-1:0] w;
    logic [N-1:0] row;
    int t;
    int j;
    t = idx / N;
    j = idx % N;
    w = '0;
    for (int k = 0; k < N; k++) begin
      if (t * N + k < nbeats) begin
        row = pat_byte(p, t * N + k);
`ifdef SWIZZLE_D2C_BIT_REVERSE_EN
        w[N-1-k] = row[j];
`else
        w[k] = row[j];
`endif
      end
    end
    return w;
  endfunction

  function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] base, input int idx);
    return base + AW'(idx / N) + AW'(STRIDE * (idx % N));
  endfunction

  task automatic drive_beats(input vec_t v);
    int budget;
    dma_mode  = v.dma;
    base_addr = v.base;
    for (int i = 0; i < v.nbeats; i++) begin
      if (i == v.gap_at) begin
        in_valid = 1'b0;
        repeat (3) tick();
      end
      in_valid = 1'b1;
      in_data  = pat_byte(v.pat, i);
      in_last  = (i == v.nbeats - 1);
      budget   = 0;
      while (!in_ready && budget < 50) begin
        tick();
        budget++;
      end
      if (!in_ready) check("in_ready timeout", 32'(in_ready), 32'd1);
      tick();
      base_addr = ~v.base;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic run_vec(input int vi, input vec_t v);
    int a0, w0, d0, v0, budget, cb, gaps;
    a0 = acc_n; w0 = wr_n; d0 = done_n; v0 = rule_viol;
    drive_beats(v);
    budget = 0;
    while (done_n == d0 && budget < 200) begin
      tick();
      budget++;
    end
    repeat (4) tick();
    check($sformatf("v%0d done count", vi), done_n - d0, 1);
    check($sformatf("v%0d write count", vi), wr_n - w0, v.exp_writes);
    if ((wr_n - w0 == v.exp_writes) && (done_n - d0 >= 1)) begin
      for (int i = 0; i < v.exp_writes; i++) begin
        check($sformatf("v%0d data[%0d]", vi, i), wr_data[w0+i], model_data(v.nbeats, v.pat, i));
        check($sformatf("v%0d addr[%0d]", vi, i), wr_addr[w0+i], model_addr(v.base, i));
      end
      cb = ((v.nbeats < N) ? v.nbeats : N) - 1;
      check($sformatf("v%0d first write latency", vi), wr_cyc[w0] - acc_cyc[a0+cb], v.exp_lat);
      gaps = 0;
      for (int i = 1; i < v.exp_writes; i++) begin
        if (wr_cyc[w0+i] != wr_cyc[w0] + i) gaps++;
      end
      check($sformatf("v%0d write gaps", vi), gaps, 0);
      check($sformatf("v%0d done after final write", vi),
            done_cyc[d0] - wr_cyc[w0+v.exp_writes-1], 1);
      if (v.gap_at < 0) begin
        check($sformatf("v%0d accept stream span", vi),
              acc_cyc[a0+v.nbeats-1] - acc_cyc[a0], v.nbeats - 1);
      end
      if (v.base == 16'hFFFC) check($sformatf("v%0d wrapped addr", vi), wr_addr[w0+1], 16'h0000);
    end
    check($sformatf("v%0d idle at end", vi), idle, 1);
    check($sformatf("v%0d in_ready at end", vi), in_ready, 1);
    check($sformatf("v%0d ready/idle rules", vi), rule_viol - v0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0, budget;
    vec_t rv;

    //          dma   base      beats pat gap writes lat
    vecs[0] = '{1'b1, 16'h0010,  8,   0,  -1,  8,    1};
    vecs[1] = '{1'b1, 16'h0010, 24,   2,  -1, 24,    1};
    vecs[2] = '{1'b1, 16'h0010,  3,   1,  -1,  8,    1};
    vecs[3] = '{1'b0, 16'h0010,  8,   0,  -1,  8,    2};
    vecs[4] = '{1'b1, 16'h0040, 13,   2,   4, 16,    1};
    vecs[5] = '{1'b1, 16'hFFFC,  8,   0,  -1,  8,    1};
    vecs[6] = '{1'b0, 16'h0300,  1,   3,  -1,  8,    2};
    vecs[7] = '{1'b0, 16'h0200, 20,   2,  -1, 24,    2};

    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    base_addr = '0; dma_mode = 1'b1;
    repeat (3) tick();
    check("reset in_ready", in_ready, 1);
    check("reset idle", idle, 1);
    check("reset done", done, 0);
    check("reset ram_we", ram_we, 0);
    check("reset ram_addr", ram_addr, 0);
    check("reset ram_data", ram_data, 0);
    reset = 1'b0;
    tick();

    for (int vi = 0; vi < 8; vi++) begin
      run_vec(vi, vecs[vi]);
      repeat (2) tick();
    end

    // Reset in the middle of a drain.
    rv = '{1'b1, 16'h0080, 8, 0, -1, 8, 1};
    w0 = wr_n;
    drive_beats(rv);
    budget = 0;
    while (wr_n == w0 && budget < 20) begin
      tick();
      budget++;
    end
    check("drain started before reset", 32'(wr_n > w0), 1);
    tick();
    reset = 1'b1;
    tick();
    check("mid-drain reset ram_we", ram_we, 0);
    check("mid-drain reset idle", idle, 1);
    check("mid-drain reset in_ready", in_ready, 1);
    check("mid-drain reset ram_addr", ram_addr, 0);
    reset = 1'b0;
    w0 = wr_n; d0 = done_n;
    repeat (15) tick();
    check("no writes after reset", wr_n - w0, 0);
    check("no done after reset", done_n - d0, 0);

    run_vec(8, vecs[2]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/swizzle_d2c_tile.md
# swizzle_d2c_tile

Parametrised DRAM-to-compute-RAM swizzle unit. It sits between the memory-controller read stream and the CRAM write port. It accepts N-bit words under a valid/ready handshake and collects them into N×N bit tiles. It transposes each tile so that output word j holds bit j of every input row, and writes the N words to the CRAMs at a strided address. Ping-pong tile buffers overlap loading and draining. Compared with the fixed 40-bit generation, it adds backpressure, partial-tile zero padding, a programmable stride and an explicit completion pulse.

## Interface
- N, 40, tile size: input word width, words per tile, output word width.
- ADDR_W, 16, CRAM address width (RAM address bits plus CRAM select bits).
- STRIDE, 4, address increment between consecutive output words of one tile.

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  input word valid
- in_ready  out  1  unit can accept a word this cycle
- in_data  in  N  input word (row)
- in_last  in  1  final word of the transfer, qualified by in_valid&in_ready
- base_addr  in  ADDR_W  CRAM start address, sampled on the first accepted beat while idle
- dma_mode  in  1  1: unregistered write outputs; 0: extra output register stage. Quasi-static; change only while idle=1.
- ram_data  out  N  transposed column word
- ram_addr  out  ADDR_W  CRAM write address
- ram_we  out  1  CRAM write enable
- idle  out  1  no tile loading, buffered or draining
- done  out  1  one-cycle pulse after the final word of a transfer is written

## Operation
- Handshake: a beat is accepted on cycle edges where in_valid & in_ready.
- Row r of the load buffer receives in_data for the r-th accepted beat of the tile, r = 0..N-1.
- Tile completion: the tile completes on the N-th accepted beat, or on an accepted beat with in_last=1.
  - Rows not written in a completed tile read as zero. The load buffer is cleared when it becomes the load side.
- Swap: at the completing edge, if the drain buffer is empty or is issuing its final word that cycle, the buffers swap and draining of the new tile begins next cycle.
  - Otherwise the load buffer is held full, in_ready=0, and the swap happens at the edge where the drain issues its final word.
- Drain: exactly N consecutive cycles with ram_we=1, words j = 0..N-1, never stalled.
  - ram_data bit k = row k, bit j of the tile.
  - ram_addr = base_addr + t + j·STRIDE, where t is the tile index within the transfer, starting at 0.
  - Address arithmetic is mod 2^ADDR_W; silent wrap.
- End of transfer: after the tile containing in_last finishes draining:
  - done pulses for one cycle, aligned with the cycle after the final ram_we (after the output stage in dma_mode=0);
  - t clears;
  - idle returns to 1.
- in_ready rules:
  - in_ready=0 from acceptance of in_last until idle=1.
  - Otherwise in_ready=1 unless the load buffer is full.
- in_last on beat N-1 is a full tile plus end of transfer; no padding.
- Reset: discards all buffered data; t cleared; no further writes issued.

## Timing
- Reset values: in_ready=1, idle=1, done=0, ram_we=0, ram_addr=0, ram_data=0.
- Latency, completing edge to first ram_we: 1 cycle with dma_mode=1; 2 cycles with dma_mode=0.
  - In dma_mode=0, ram_data, ram_addr and ram_we are delayed together by one register.
- Sustained throughput is one word per cycle. Continuous input with in_valid=1 never deasserts in_ready.
- idle deasserts the cycle after the first accepted beat.

## Configuration
- SWIZZLE_D2C_BIT_REVERSE_EN defined: ram_data bit i = transposed bit N-1-i. This is the legacy CRAM bit ordering.
- Not defined: natural ordering, ram_data bit k = row k.
- Addressing and timing are identical in both cases.

## Structure
- Shared package swizzle_pkg holds:
  - default N, ADDR_W and STRIDE constants;
  - the drain-state enum (D_IDLE, D_DRAIN);
  - the transfer-state enum (T_IDLE, T_LOAD, T_FLUSH).
- One sub-module, swizzle_tile_buffer: N×N flop array with synchronous clear, row write (index, data, enable) and column read (index).
  - Instantiated twice (ping, pong).
  - Top level holds the counters, swap control and output stage.

## Test plan
- N=8, STRIDE=4, dma_mode=1, base=0x10, 8 beats 0x01,0x02,0x04..0x80 with last on beat 8:
  - ram_data = 0x01,0x02..0x80;
  - addresses 0x10,0x14..0x2C;
  - first ram_we 1 cycle after the 8th beat;
  - done one cycle after the final write.
- N=8, 24 continuous beats with last on beat 24:
  - in_ready stays 1;
  - 24 consecutive writes;
  - tile bases 0x10, 0x11, 0x12.
- Partial tile, 3 beats 0xFF with last:
  - 8 writes, each ram_data=0x07 (0xE0 with BIT_REVERSE_EN);
  - idle returns to 1.
- dma_mode=0, repeat the first scenario: identical data/address sequence shifted by one cycle.
- Backpressure: hold in_valid low for 3 cycles mid-tile, then burst. Assert reset during a drain: ram_we=0 next cycle, idle=1, in_ready=1.
- base_addr = 2^ADDR_W−4, STRIDE=4: second address wraps to 0.
